// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and size decoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} lsu_state_t;

  // Access size in bytes; 0 marks a code that is not a load size.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic write, input logic [2:0] funct3);
    if (write) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return size_of(funct3) != 3'd0;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake plus data-memory port of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic [DM_ADDRESS-3:0] mem_addr;
  logic                  mem_re;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_re, mem_we, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_re, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store enables/data across two words, load shift and extend.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wd0,
  output logic [31:0] wd1,
  output logic [31:0] rdata
);
  logic [7:0]  lanes;
  logic [7:0]  en;
  logic [31:0] bmask;
  logic [63:0] dat;
  logic [63:0] shifted;

  always_comb begin
    case (size_of(funct3))
      3'd1:    lanes = 8'h01;
      3'd2:    lanes = 8'h03;
      3'd4:    lanes = 8'h0f;
      default: lanes = 8'h00;
    endcase
    en    = lanes << offset;
    bmask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    // Lanes that spill past byte 3 land in the following word.
    dat     = {32'b0, wdata & bmask} << {offset, 3'b000};
    be0     = en[3:0];
    be1     = en[7:4];
    wd0     = dat[31:0];
    wd1     = dat[63:32];
    shifted = {word1, word0} >> {offset, 3'b000};
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata = shifted[31:0];
      F3_BU:   rdata = {24'b0, shifted[7:0]};
      F3_HU:   rdata = {16'b0, shifted[15:0]};
      default: rdata = 32'b0;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into one or two word accesses and a response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input logic             clk,
  input logic             rst_n,
  load_store_unit_if.slave bus
);
  localparam int unsigned WW = DM_ADDRESS - 2;

  lsu_state_t            state_q, state_d;
  logic                  write_q, err_q;
  logic [2:0]            f3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q, word0_q;

  logic [WW-1:0]     w0, w1;
  logic              split;
  logic [3:0]        be0, be1;
  logic [DATA_W-1:0] wd0, wd1, ld_data, ld_word0;

  assign w0       = addr_q[DM_ADDRESS-1:2];
  assign w1       = w0 + WW'(1);
  assign split    = ({1'b0, addr_q[1:0]} + size_of(f3_q)) > 3'd4;
  // Non-split loads take their only word straight from the memory read port.
  assign ld_word0 = split ? word0_q : bus.mem_rdata;

  lsu_lane_align u_align (
    .funct3 (f3_q),
    .offset (addr_q[1:0]),
    .wdata  (wdata_q),
    .word0  (ld_word0),
    .word1  (bus.mem_rdata),
    .be0    (be0),
    .be1    (be1),
    .wd0    (wd0),
    .wd1    (wd1),
    .rdata  (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word0_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid) begin
        write_q <= bus.req_write;
        err_q   <= !is_legal(bus.req_write, bus.req_funct3);
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == ACC1) word0_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_be     = 4'b0;
    bus.mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = is_legal(bus.req_write, bus.req_funct3) ? ACC0 : DONE;
      end
      ACC0: begin
        bus.mem_addr = w0;
        if (write_q) begin
          bus.mem_we    = 1'b1;
          bus.mem_be    = be0;
          bus.mem_wdata = wd0;
        end else begin
          bus.mem_re = 1'b1;
        end
        state_d = split ? ACC1 : DONE;
      end
      ACC1: begin
        bus.mem_addr = w1;
        if (write_q) begin
          bus.mem_we    = 1'b1;
          bus.mem_be    = be1;
          bus.mem_wdata = wd1;
        end else begin
          bus.mem_re = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        if (!write_q && !err_q) bus.resp_rdata = ld_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: byte-array reference memory versus a word memory driven by the DUT.
module tb_load_store_unit;
  localparam int unsigned DM_ADDRESS = 9;
  localparam int unsigned WORDS      = 128;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  load_store_unit_if #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(32)) bus ();

  load_store_unit #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [WORDS];
  logic        init_en = 1'b0;
  logic [6:0]  init_idx = '0;
  logic [31:0] init_val = '0;
  logic [7:0]  ref_mem [512];
  acc_t        log_q [$];

  always @(posedge clk) begin
    if (init_en) mem[init_idx] <= init_val;
    else if (bus.mem_we)
      for (int i = 0; i < 4; i++)
        if (bus.mem_be[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_re || bus.mem_we)
        log_q.push_back(acc_t'{we: bus.mem_we, addr: bus.mem_addr, be: bus.mem_be,
                               data: bus.mem_wdata});
      checks++;
      if (bus.mem_re && bus.mem_we) begin
        errors++;
        $display("FAIL strobe_exclusive: re=%b we=%b, required not both", bus.mem_re, bus.mem_we);
      end
      checks++;
      if (!bus.resp_valid && bus.resp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL rdata_idle: got %h, required 0", bus.resp_rdata);
      end
    end
  end

  // Reference model: byte-addressed memory, wrapping at 512 bytes.
  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic ref_legal(input logic w, input logic [2:0] f3);
    if (w) return f3 <= 3'd2;
    return ref_size(f3) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [8:0] addr);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < ref_size(f3); i++) v[8*i +: 8] = ref_mem[(int'(addr) + i) % 512];
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] wd,
                           input logic first_only);
    for (int i = 0; i < ref_size(f3); i++) begin
      int a = (int'(addr) + i) % 512;
      if (!first_only || (a / 4) == (int'(addr) / 4)) ref_mem[a] = wd[8*i +: 8];
    end
  endtask

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  task automatic test_reset();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_re !== 1'b0 ||
        bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0 || bus.mem_wdata !== 32'h0 ||
        bus.mem_addr !== 7'h0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b re=%b we=%b be=%h wd=%h a=%h rd=%h, required 1/0",
               bus.req_ready, bus.resp_valid, bus.mem_re, bus.mem_we, bus.mem_be, bus.mem_wdata,
               bus.mem_addr, bus.resp_rdata);
    end
  endtask

  task automatic test_aligned();
    log_q.delete();
    run_req(1'b1, 3'd2, 9'h010, 32'hDEADBEEF, rd, er, lat);
    ref_store(3'd2, 9'h010, 32'hDEADBEEF, 1'b0);
    checks++;
    if (lat != 2 || log_q.size() != 1 || log_q[0].we !== 1'b1 || log_q[0].addr !== 7'd4 ||
        log_q[0].be !== 4'hF || log_q[0].data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_aligned: lat=%0d n=%0d, required lat 2, one write idx 4 be f DEADBEEF",
               lat, log_q.size());
    end
    log_q.delete();
    run_req(1'b0, 3'd2, 9'h010, 32'h0, rd, er, lat);
    checks++;
    if (lat != 2 || rd !== 32'hDEADBEEF || er !== 1'b0 || log_q.size() != 1 ||
        log_q[0].we !== 1'b0 || log_q[0].addr !== 7'd4) begin
      errors++;
      $display("FAIL lw_aligned: lat=%0d rd=%h err=%b, required lat 2 DEADBEEF err 0", lat, rd, er);
    end
  endtask

  task automatic test_byte();
    log_q.delete();
    run_req(1'b1, 3'd0, 9'h013, 32'h12345680, rd, er, lat);
    ref_store(3'd0, 9'h013, 32'h12345680, 1'b0);
    checks++;
    if (log_q.size() != 1 || log_q[0].be !== 4'b1000 || log_q[0].data !== 32'h80000000) begin
      errors++;
      $display("FAIL sb_lanes: n=%0d, required one write be 1000 data 80000000", log_q.size());
    end
    run_req(1'b0, 3'd0, 9'h013, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL lb_sign: got %h, required FFFFFF80", rd);
    end
    run_req(1'b0, 3'd4, 9'h013, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu_zero: got %h, required 00000080", rd);
    end
  endtask

  task automatic test_split_load();
    run_req(1'b1, 3'd2, 9'h00C, 32'h44332211, rd, er, lat);
    ref_store(3'd2, 9'h00C, 32'h44332211, 1'b0);
    run_req(1'b1, 3'd2, 9'h010, 32'h88776655, rd, er, lat);
    ref_store(3'd2, 9'h010, 32'h88776655, 1'b0);
    log_q.delete();
    run_req(1'b0, 3'd2, 9'h00E, 32'h0, rd, er, lat);
    checks++;
    if (lat != 3 || rd !== 32'h66554433 || log_q.size() != 2 || log_q[0].addr !== 7'd3 ||
        log_q[1].addr !== 7'd4 || log_q[0].we !== 1'b0 || log_q[1].we !== 1'b0) begin
      errors++;
      $display("FAIL lw_split: lat=%0d rd=%h n=%0d, required lat 3 66554433 reads 3,4",
               lat, rd, log_q.size());
    end
    run_req(1'b0, 3'd5, 9'h00F, 32'h0, rd, er, lat);
    checks++;
    if (lat != 3 || rd !== 32'h00005544) begin
      errors++;
      $display("FAIL lhu_split: lat=%0d rd=%h, required lat 3 00005544", lat, rd);
    end
  endtask

  task automatic test_wrap();
    log_q.delete();
    run_req(1'b1, 3'd1, 9'h1FF, 32'h0000ABCD, rd, er, lat);
    ref_store(3'd1, 9'h1FF, 32'h0000ABCD, 1'b0);
    checks++;
    if (lat != 3 || log_q.size() != 2 || log_q[0].addr !== 7'd127 || log_q[0].be !== 4'b1000 ||
        log_q[0].data !== 32'hCD000000 || log_q[1].addr !== 7'd0 || log_q[1].be !== 4'b0001 ||
        log_q[1].data !== 32'h000000AB) begin
      errors++;
      $display("FAIL sh_wrap: lat=%0d n=%0d, required 127/1000/CD000000 then 0/0001/000000AB",
               lat, log_q.size());
    end
    run_req(1'b0, 3'd1, 9'h1FF, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFFABCD) begin
      errors++;
      $display("FAIL lh_wrap: got %h, required FFFFABCD", rd);
    end
  endtask

  task automatic test_illegal();
    log_q.delete();
    run_req(1'b0, 3'd3, 9'h020, 32'h0, rd, er, lat);
    checks++;
    if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || log_q.size() != 0) begin
      errors++;
      $display("FAIL illegal_load: lat=%0d err=%b rd=%h acc=%0d, required 1/1/0/0",
               lat, er, rd, log_q.size());
    end
    run_req(1'b1, 3'd4, 9'h024, 32'hFFFFFFFF, rd, er, lat);
    checks++;
    if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || log_q.size() != 0) begin
      errors++;
      $display("FAIL illegal_store: lat=%0d err=%b rd=%h acc=%0d, required 1/1/0/0",
               lat, er, rd, log_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic saw_resp = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 9'h042;
    bus.req_wdata  = 32'h11223344;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 7'h11) begin
      errors++;
      $display("FAIL acc1_reached: we=%b addr=%h, required 1/11", bus.mem_we, bus.mem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_abort: we=%b re=%b rdy=%b, required 0/0/1",
               bus.mem_we, bus.mem_re, bus.req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) saw_resp = 1'b1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (bus.resp_valid) saw_resp = 1'b1;
    checks++;
    if (saw_resp !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_resp: resp=%b rdy=%b, required 0/1", saw_resp, bus.req_ready);
    end
    ref_store(3'd2, 9'h042, 32'h11223344, 1'b1);
    run_req(1'b0, 3'd2, 9'h040, 32'h0, rd, er, lat);
    checks++;
    if (lat != 2 || rd !== ref_load(3'd2, 9'h040)) begin
      errors++;
      $display("FAIL lw_after_reset: lat=%0d rd=%h, required 2 %h", lat, rd, ref_load(3'd2, 9'h040));
    end
    run_req(1'b0, 3'd2, 9'h044, 32'h0, rd, er, lat);
    checks++;
    if (rd !== ref_load(3'd2, 9'h044)) begin
      errors++;
      $display("FAIL second_half_dropped: rd=%h, required %h", rd, ref_load(3'd2, 9'h044));
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 80; k++) begin
      logic        w    = 1'($urandom);
      logic [2:0]  f3   = 3'($urandom);
      logic [8:0]  addr = 9'($urandom);
      logic [31:0] wd   = $urandom;
      logic        leg  = ref_legal(w, f3);
      int          n    = ref_size(f3);
      int          xlat = !leg ? 1 : ((int'(addr[1:0]) + n > 4) ? 3 : 2);
      logic [31:0] xrd  = (leg && !w) ? ref_load(f3, addr) : 32'h0;
      run_req(w, f3, addr, wd, rd, er, lat);
      if (leg && w) ref_store(f3, addr, wd, 1'b0);
      checks++;
      if (lat != xlat || er !== !leg || rd !== xrd) begin
        errors++;
        $display("FAIL random[%0d] w=%b f3=%0d a=%h: lat=%0d err=%b rd=%h, required %0d %b %h",
                 k, w, f3, addr, lat, er, rd, xlat, !leg, xrd);
      end
    end
    for (int i = 0; i < WORDS; i++) begin
      logic [31:0] xw = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
      checks++;
      if (mem[i] !== xw) begin
        errors++;
        $display("FAIL mem_image[%0d]: got %h, required %h", i, mem[i], xw);
      end
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    #2;
    test_reset();
    for (int i = 0; i < WORDS; i++) begin
      init_val = $urandom;
      init_idx = 7'(i);
      init_en  = 1'b1;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = init_val[8*b +: 8];
      @(posedge clk); #1;
    end
    init_en = 1'b0;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_aligned();
    test_byte();
    test_split_load();
    test_wrap();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the word-organised data memory. It accepts one load/store per transaction from the execute/memory pipeline stage and converts RISC-V byte, half and word accesses into word-indexed memory reads and byte-enabled writes. Misaligned accesses are split into two word accesses, and load data is sign- or zero-extended before return. It sits between the pipeline's memory stage and the data memory array.

## Interface
- DM_ADDRESS, 9: byte-address width; memory holds 2^(DM_ADDRESS-2) words.
- DATA_W, 32: data width; only 32 is supported.
- clk  in  1  clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; a transfer happens when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  instruction bits 14:12.
- req_addr  in  DM_ADDRESS  byte address.
- req_wdata  in  DATA_W  store data; the low bytes are used.
- resp_valid  out  1  one-cycle completion pulse for every accepted request.
- resp_rdata  out  DATA_W  extended load data; 0 whenever resp_valid=0 and for stores.
- resp_err  out  1  illegal funct3; qualified by resp_valid.
- mem_addr  out  DM_ADDRESS-2  word index.
- mem_re  out  1  read strobe; data is returned on mem_rdata the next cycle.
- mem_we  out  1  write strobe; memory commits on this cycle's edge.
- mem_be  out  4  byte enables; lane i = bits 8i+7:8i.
- mem_wdata  out  DATA_W  lane-aligned write data.
- mem_rdata  in  DATA_W  read data, one cycle after mem_re.

## Operation
- Size n per funct3:
  - Loads: 000 LB (n=1, signed), 001 LH (n=2, signed), 010 LW (n=4), 100 LBU (n=1, zero-extended), 101 LHU (n=2, zero-extended).
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- Offset o = addr[1:0]; w0 = addr[DM_ADDRESS-1:2]; w1 = w0+1 modulo the word count (wraps at the top of memory to 0).
- Split when o+n > 4.
- Store lanes: 8-lane enable E = ((1<<n)-1) << o and 64-bit data D = (wdata low n bytes) << 8o. Word w0 gets E[3:0]/D[31:0]; word w1 gets E[7:4]/D[63:32]. Enables are strictly those lanes, so no read-modify-write is needed.
- Load: form {word1, word0}, shift right by 8o, keep the low n bytes, then extend per funct3. The request fields and word0 are captured in registers.
- FSM states: IDLE, ACC0, ACC1, DONE.
  - IDLE: req_ready=1. On a transfer, capture the request. Legal → ACC0; illegal → DONE with err flagged.
  - ACC0: drive w0 access (mem_re, or mem_we with mem_be/mem_wdata). Split → ACC1, else → DONE.
  - ACC1: drive w1 access; register mem_rdata as word0. → DONE.
  - DONE: resp_valid=1; resp_rdata assembled from the registered word0 and the current mem_rdata (non-split: word1 unused). → IDLE.
- req_ready=0 outside IDLE; req_valid is ignored while busy.
- mem_re/mem_we are never both 1. Neither is asserted in IDLE or DONE, nor for illegal requests.

## Timing
- Request accepted at edge T:
  - Aligned (non-split): memory access in cycle T+1, resp_valid in T+2.
  - Split: accesses in T+1 and T+2, resp_valid in T+3.
  - Illegal: resp_valid with resp_err=1 in T+1, no memory access.
- Back-to-back: the next accept is possible in the cycle after DONE.
- Reset values: state IDLE; req_ready=1; all other outputs 0, including mem_be, mem_wdata and mem_addr.
- Reset mid-transaction (any state):
  - Immediate return to IDLE; mem_we/mem_re drop asynchronously.
  - The second half of a split store is not issued; the first half may already be committed.
  - No resp_valid is produced for the aborted request.

## Structure
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum lsu_state_t {IDLE, ACC0, ACC1, DONE};
  - function size_of(funct3).
- Sub-module lsu_lane_align: purely combinational store lane/enable generation and load shift/extend. The FSM and registers stay in load_store_unit.

## Test plan
- SW 0xDEADBEEF @0x010, then LW @0x010 → mem_addr=4, mem_be=1111; load resp_rdata=0xDEADBEEF at T+2.
- SB 0x80 @0x013 → mem_be=1000, mem_wdata=0x80000000. LB @0x013 → 0xFFFFFF80; LBU → 0x00000080.
- Words 3=0x44332211, 4=0x88776655. LW @0x00E → reads idx 3 then 4, resp 0x66554433 at T+3. LHU @0x00F → 0x00005544.
- SH 0xABCD @0x1FF → word 127 be=1000 data=0xCD000000, then word 0 be=0001 data=0x000000AB.
- funct3=011 load, and store with funct3=100 → no mem strobe; resp_valid and resp_err=1 at T+1; resp_rdata=0.
- rst_n low during ACC1 of a split store → mem_we=0 immediately, no resp_valid. After release, req_ready=1 and a following LW completes normally.
